// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 8;
  localparam int unsigned MUL_CNT_W = 3;
  localparam int unsigned MUL_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_t;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder. Every carry is a flat sum of products of the
// bit generate/propagate terms, so no carry ripples through earlier carries.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    logic t_c;
    logic t_p;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      t_c = 1'b0;
      t_p = 1'b1;
      for (int j = i; j >= 0; j--) begin
        t_c = t_c | (t_p & g[j]);
        t_p = t_p & p[j];
      end
      c[i+1] = t_c | (t_p & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/shift_add_mul8.sv
// Iterative 8x8 unsigned shift-and-add multiplier, one step per clock.
// Optional feature macro: MUL_ZERO_BYPASS_EN (zero operand skips CALC).
module shift_add_mul8
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MUL_STEPS - 1);

  mul_state_t         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_co;

  // Multiplier bit 0 gates the multiplicand, so the adder passes acc high half through otherwise.
  assign add_b   = acc_q[0] ? m_q : '0;
  assign cnt_inc = cnt_q + CNT_W'(1);

  cla_8bit u_cla (
    .a    (acc_q[2*WIDTH-1:WIDTH]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_co)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = CALC;
`ifdef MUL_ZERO_BYPASS_EN
          if ((a == '0) || (b == '0)) begin
            acc_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        // Adder carry lands in acc[15] after the right shift.
        acc_d = {add_co, add_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_inc;
        if (cnt_q == LastCnt) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = acc_q;

endmodule
